// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings for the instruction-fetch front end.
package fetch_pkg;

    // Next-PC select encodings driven by control (2'b11 is reserved, behaves as +4).
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection.
// Without FETCH_MISALIGN_TRAP_EN the result is forced to word alignment; with it the
// raw target is passed through so the fetch unit can detect and trap on misalignment.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int unsigned D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] pc,
    input  logic [1:0]         pcsrc,
    input  logic [D_WIDTH-1:0] immext,
    input  logic [D_WIDTH-1:0] aluresult,
    output logic [D_WIDTH-1:0] next_pc
);

    logic [D_WIDTH-1:0] target;

    // Select the raw target; all additions wrap silently.
    always_comb begin
        target = pc + D_WIDTH'(4);
        case (pcsrc)
            PCSRC_PLUS4:  target = pc + D_WIDTH'(4);
            PCSRC_BRANCH: target = pc + immext;
            PCSRC_JALR:   target = aluresult & ~D_WIDTH'(1);
            default:      target = pc + D_WIDTH'(4);
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        next_pc = target;
`else
        next_pc = target & ~D_WIDTH'(3);
`endif
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch front end. Owns the PC, issues one imem request
// per instruction, holds the returned word for decode and forms the next PC on each
// decode handshake.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds fetch_fault and a sticky FAULT
// state entered when the next PC is not word aligned).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [D_WIDTH-1:0] PC,
    output logic [D_WIDTH-1:0] PCPlus4,
    input  logic [1:0]         PCSrc,
    input  logic [D_WIDTH-1:0] ImmExt,
    input  logic [D_WIDTH-1:0] ALUResult,
    output logic [31:0]        fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               fetch_fault
`endif
);

    fetch_state_e       state_q, state_d;
    logic [D_WIDTH-1:0] pc_q;
    logic [31:0]        instr_q;
    logic [31:0]        count_q;
    logic [D_WIDTH-1:0] next_pc;
    logic               handshake;

    pc_next_mux #(
        .D_WIDTH (D_WIDTH)
    ) u_pc_next_mux (
        .pc        (pc_q),
        .pcsrc     (PCSrc),
        .immext    (ImmExt),
        .aluresult (ALUResult),
        .next_pc   (next_pc)
    );

    assign handshake   = (state_q == StHold) && instr_ready;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + D_WIDTH'(4);
    assign instr       = instr_q;
    assign fetch_count = count_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == StFault);
`endif

    // Next-state and handshake outputs of the fetch FSM.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) state_d = StHold;
            end
            StHold: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = (next_pc[1:0] != 2'b00) ? StFault : StReq;
`else
                    state_d = StReq;
`endif
                end
            end
            // Sticky until reset.
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    // State, PC, held instruction and handshake counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StWait) && imem_rvalid) instr_q <= imem_rdata;
            if (handshake) begin
                pc_q    <= next_pc;
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule
